// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - size codes, FSM states and mask helper shared by the LSU memory master
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Reserved size code 3 behaves as a word.
  function automatic logic [3:0] size_to_mask(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_to_mask = 4'b0001;
      SIZE_HALF: size_to_mask = 4'b0011;
      default:   size_to_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational lane steering: store enables/data for both word halves, load merge and extend
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] lo_word,
  input  logic [31:0] hi_word,
  output logic        crossing,
  output logic [3:0]  lo_wen,
  output logic [3:0]  hi_wen,
  output logic [31:0] lo_wdata,
  output logic [31:0] hi_wdata,
  output logic [31:0] rdata
);

  logic [3:0]  mask;
  logic [7:0]  mask_wide;
  logic [4:0]  lo_shamt;
  logic [5:0]  hi_shamt;
  logic [63:0] pair;
  logic [63:0] shifted;
  logic [31:0] merged;

  always_comb begin
    mask      = size_to_mask(size);
    mask_wide = {4'b0000, mask} << off;
    lo_shamt  = {off, 3'b000};
    hi_shamt  = 6'd32 - {1'b0, lo_shamt};
    // An access crosses exactly when its enables spill into the next word.
    crossing  = mask_wide[7:4] != 4'b0000;
    lo_wen    = mask_wide[3:0];
    hi_wen    = mask_wide[7:4];
    lo_wdata  = wdata << lo_shamt;
    hi_wdata  = wdata >> hi_shamt;
    pair      = {(crossing ? hi_word : 32'h0), lo_word};
    shifted   = pair >> lo_shamt;
    merged    = shifted[31:0];
    case (size)
      SIZE_BYTE: rdata = {{24{is_signed & merged[7]}}, merged[7:0]};
      SIZE_HALF: rdata = {{16{is_signed & merged[15]}}, merged[15:0]};
      default:   rdata = merged;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store unit master for a word RAM, splitting word-crossing accesses
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses fault instead of being split.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wenable,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       lo_word_q, lo_word_d;
  logic [31:0]       hi_word_q, hi_word_d;
  logic              fault_q, fault_d;

  logic              trap;
  logic              crossing;
  logic [3:0]        lo_wen, hi_wen;
  logic [31:0]       lo_wdata, hi_wdata, ld_data;
  logic [ADDR_W-3:0] hi_index;

`ifdef LSU_MISALIGN_TRAP_EN
  logic [3:0] req_mask;
  assign req_mask = size_to_mask(req_size);
  assign trap     = |(req_addr[1:0] & req_mask[2:1]);
`else
  assign trap = 1'b0;
`endif

  assign hi_index = addr_q[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};

  lsu_align u_align (
    .off       (addr_q[1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .lo_word   (lo_word_q),
    .hi_word   (hi_word_q),
    .crossing  (crossing),
    .lo_wen    (lo_wen),
    .hi_wen    (hi_wen),
    .lo_wdata  (lo_wdata),
    .hi_wdata  (hi_wdata),
    .rdata     (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    lo_word_d   = lo_word_q;
    hi_word_d   = hi_word_q;
    fault_d     = fault_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_addr    = RESET_ADDR;
    mem_wenable = 4'b0000;
    mem_wdata   = 32'h0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d    = req_addr;
          we_d      = req_we;
          size_d    = req_size;
          signed_d  = req_signed;
          wdata_d   = req_wdata;
          lo_word_d = 32'h0;
          hi_word_d = 32'h0;
          fault_d   = trap;
          state_d   = trap ? RESP : LO;
        end
      end
      LO: begin
        mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (we_q) begin
          mem_wenable = lo_wen;
          mem_wdata   = lo_wdata;
        end else begin
          lo_word_d = mem_rdata;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        state_d = RESP;
`else
        state_d = crossing ? HI : RESP;
`endif
      end
`ifndef LSU_MISALIGN_TRAP_EN
      HI: begin
        mem_addr = {hi_index, 2'b00};
        if (we_q) begin
          mem_wenable = hi_wen;
          mem_wdata   = hi_wdata;
        end else begin
          hi_word_d = mem_rdata;
        end
        state_d = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset kills the in-flight write in the same cycle it is raised.
    if (rst) mem_wenable = 4'b0000;
  end

  assign resp_rdata = (state_q == RESP && !we_q && !fault_q) ? ld_data : 32'h0;
  assign resp_fault = (state_q == RESP) & fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      size_q    <= SIZE_BYTE;
      signed_q  <= 1'b0;
      wdata_q   <= 32'h0;
      lo_word_q <= 32'h0;
      hi_word_q <= 32'h0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      size_q    <= size_d;
      signed_q  <= signed_d;
      wdata_q   <= wdata_d;
      lo_word_q <= lo_word_d;
      hi_word_q <= hi_word_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - self-checking bench for lsu_mem_master, byte-level reference model
// Honours LSU_MISALIGN_TRAP_EN when defined for the build.
module tb_lsu_mem_master;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wenable;

  always #5 clk = ~clk;

  lsu_mem_master #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable), .mem_rdata(mem_rdata)
  );

  logic [31:0] tb_mem [0:1023];
  assign mem_rdata = tb_mem[mem_addr[11:2]];
  always @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (mem_wenable[i]) tb_mem[mem_addr[11:2]][8*i +: 8] <= mem_wdata[8*i +: 8];

  logic [7:0]  ref_mem [int unsigned];
  int          checks = 0, failures = 0, addr_bad = 0;
  logic [31:0] cyc_addr [4];
  logic [31:0] cyc_wdata [4];
  logic [3:0]  cyc_wen [4];

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;
  vec_t vt [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  task automatic model_access(input logic [31:0] a, input logic we, input logic [1:0] sz,
                              input logic sg, input logic [31:0] wd, output logic [31:0] rd,
                              output logic flt, output int lat, output int wen_cyc);
    int n;
    logic [31:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    flt = TRAP && ((a % n) != 0);
    rd = 32'h0;
    wen_cyc = 0;
    lat = 1;
    if (!flt) begin
      lat = (int'(a[1:0]) + n > 4) ? 3 : 2;
      if (we) begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        wen_cyc = lat - 1;
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd_byte(a + 32'(i));
        if (sg && n < 4 && v[8*n-1])
          for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic sg, input logic [31:0] wd, output int lat, output int wen_cyc);
    int w;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_size = sz; req_signed = sg; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_ready_before_accept", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    wen_cyc = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= 4) begin
        cyc_addr[lat-1] = mem_addr; cyc_wen[lat-1] = mem_wenable; cyc_wdata[lat-1] = mem_wdata;
      end
      if (mem_addr[1:0] != 2'b00) addr_bad++;
      if (!resp_valid && mem_wenable != 4'h0) wen_cyc++;
    end while (!resp_valid && lat < 20);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic run_access(input logic [31:0] a, input logic we, input logic [1:0] sz,
                            input logic sg, input logic [31:0] wd, output logic [31:0] rd,
                            output int lat);
    int wen_cyc, e_lat, e_wen;
    logic flt, e_flt;
    logic [31:0] e_rd;
    issue(a, we, sz, sg, wd, lat, wen_cyc);
    rd = resp_rdata;
    flt = resp_fault;
    finish_resp();
    model_access(a, we, sz, sg, wd, e_rd, e_flt, e_lat, e_wen);
    chk($sformatf("rdata a=%h we=%0d sz=%0d", a, we, sz), rd, e_rd);
    chk($sformatf("latency a=%h sz=%0d", a, sz), 32'(lat), 32'(e_lat));
    chk($sformatf("wen_cycles a=%h we=%0d", a, we), 32'(wen_cyc), 32'(e_wen));
    chk($sformatf("fault a=%h sz=%0d", a, sz), {31'b0, flt}, {31'b0, e_flt});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a, r_hold, e_rd;
    int lat, wen_cyc, e_lat, e_wen;
    logic e_flt;

    for (int i = 0; i < 1024; i++) tb_mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_wdata = 32'h0; resp_ready = 1'b0;

    vt[0]  = '{32'h00000100, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'h00000000, 2};
    vt[1]  = '{32'h00000100, 1'b0, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 2};
    vt[2]  = '{32'h00000100, 1'b1, 2'd2, 1'b0, 32'h80FF7F01, 32'h00000000, 2};
    vt[3]  = '{32'h00000102, 1'b0, 2'd0, 1'b1, 32'h0,        32'hFFFFFFFF, 2};
    vt[4]  = '{32'h00000102, 1'b0, 2'd0, 1'b0, 32'h0,        32'h000000FF, 2};
    vt[5]  = '{32'h00000100, 1'b0, 2'd1, 1'b1, 32'h0,        32'h00007F01, 2};
    vt[6]  = '{32'h00000103, 1'b1, 2'd2, 1'b0, 32'h11223344, 32'h00000000, 3};
    vt[7]  = '{32'h00000103, 1'b0, 2'd2, 1'b0, 32'h0,        32'h11223344, 3};
    vt[8]  = '{32'hFFFFFFFF, 1'b1, 2'd1, 1'b0, 32'h0000A55A, 32'h00000000, 3};
    vt[9]  = '{32'hFFFFFFFF, 1'b0, 2'd1, 1'b0, 32'h0,        32'h0000A55A, 3};
    vt[10] = '{32'hFFFFFFFF, 1'b0, 2'd1, 1'b1, 32'h0,        32'hFFFFA55A, 3};
    vt[11] = '{32'h00000104, 1'b0, 2'd0, 1'b0, 32'h0,        32'h00000033, 2};
    vt[12] = '{32'h00000104, 1'b0, 2'd3, 1'b0, 32'h0,        32'h00112233, 2};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_wenable", {28'b0, mem_wenable}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'h0);
    chk("reset_resp_fault", {31'b0, resp_fault}, 32'd0);
    chk("reset_mem_addr", mem_addr, 32'h0);
    chk("reset_mem_wenable", {28'b0, mem_wenable}, 32'h0);
    chk("reset_mem_wdata", mem_wdata, 32'h0);

    for (int i = 0; i < 13; i++) begin
      run_access(vt[i].addr, vt[i].we, vt[i].size, vt[i].sgn, vt[i].wdata, rd, lat);
`ifndef LSU_MISALIGN_TRAP_EN
      chk($sformatf("table%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("table%0d_latency", i), 32'(lat), 32'(vt[i].exp_lat));
`endif
    end

`ifndef LSU_MISALIGN_TRAP_EN
    run_access(32'h203, 1'b1, 2'd2, 1'b0, 32'h11223344, rd, lat);
    chk("split_lo_addr", cyc_addr[0], 32'h200);
    chk("split_lo_wen", {28'b0, cyc_wen[0]}, 32'h8);
    chk("split_lo_lane3", {24'b0, cyc_wdata[0][31:24]}, 32'h44);
    chk("split_hi_addr", cyc_addr[1], 32'h204);
    chk("split_hi_wen", {28'b0, cyc_wen[1]}, 32'h7);
    chk("split_hi_wdata", {8'b0, cyc_wdata[1][23:0]}, 32'h112233);

    run_access(32'hFFFFFFFF, 1'b0, 2'd1, 1'b0, 32'h0, rd, lat);
    chk("wrap_lo_addr", cyc_addr[0], 32'hFFFFFFFC);
    chk("wrap_hi_addr", cyc_addr[1], 32'h00000000);

    // Reset raised while the second half of a crossing store is on the bus.
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h401; req_we = 1'b1; req_size = 2'd2; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_lo_addr", mem_addr, 32'h400);
    chk("abort_lo_wen", {28'b0, mem_wenable}, 32'hE);
    @(negedge clk);
    chk("abort_hi_addr", mem_addr, 32'h404);
    chk("abort_hi_wen", {28'b0, mem_wenable}, 32'h1);
    rst = 1'b1;
    #1 chk("abort_wen_gated", {28'b0, mem_wenable}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort_wen", {28'b0, mem_wenable}, 32'h0);
    ref_mem[32'h401] = 8'hBE; ref_mem[32'h402] = 8'hBA; ref_mem[32'h403] = 8'hFE;
    run_access(32'h400, 1'b0, 2'd2, 1'b0, 32'h0, rd, lat);
    chk("abort_lo_committed", rd, 32'hFEBABE00);
    run_access(32'h404, 1'b0, 2'd0, 1'b0, 32'h0, rd, lat);
    chk("abort_hi_dropped", rd, 32'h0);
`else
    run_access(32'h101, 1'b1, 2'd1, 1'b0, 32'hBEEF, rd, lat);
    chk("trap_latency", 32'(lat), 32'd1);
    chk("trap_no_wen", {28'b0, cyc_wen[0]}, 32'h0);
    run_access(32'h200, 1'b1, 2'd2, 1'b0, 32'h13579BDF, rd, lat);
    run_access(32'h200, 1'b0, 2'd2, 1'b0, 32'h0, rd, lat);
    chk("trap_aligned_rdata", rd, 32'h13579BDF);
    chk("trap_aligned_latency", 32'(lat), 32'd2);
`endif

    // Response backpressure with a new request waiting.
    model_access(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, e_rd, e_flt, e_lat, e_wen);
    issue(32'h100, 1'b0, 2'd2, 1'b0, 32'h0, lat, wen_cyc);
    chk("bp_latency", 32'(lat), 32'd2);
    req_valid = 1'b1; req_addr = 32'h104; req_we = 1'b1; req_size = 2'd2; req_wdata = 32'h55AA55AA;
    r_hold = resp_rdata;
    chk("bp_rdata", r_hold, e_rd);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_resp_valid", k), {31'b0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_req_ready", k), {31'b0, req_ready}, 32'd0);
      chk($sformatf("bp%0d_wen", k), {28'b0, mem_wenable}, 32'h0);
      chk($sformatf("bp%0d_rdata_stable", k), resp_rdata, e_rd);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("bp_after_req_ready", {31'b0, req_ready}, 32'd1);
    chk("bp_after_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("bp_after_wen", {28'b0, mem_wenable}, 32'h0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 3) a = 32'h100 + $urandom_range(0, 63);
      else a = 32'hFFFFFFF0 + $urandom_range(0, 15);
      run_access(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom, rd, lat);
    end

    chk("mem_addr_word_aligned", 32'(addr_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
